// File: rtl/zap_mem_fill_ctrl.sv
// Line-fill writer for the invalidate-capable cache RAM.
// Fetches one aligned line of BEATS words over a Wishbone-classic master port
// and writes each returned word into the RAM one cycle after its ack.
// A bulk invalidate or a bus error aborts the fill; no further RAM writes
// occur for that line afterwards.
module zap_mem_fill_ctrl #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BEATS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_req,
  input  logic [31:0]              i_req_addr,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_abort,
  output logic                     o_err,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic [31:0]              o_wb_adr,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [WIDTH-1:0]         i_wb_dat,
  input  logic                     i_inv,
  output logic                     o_mem_wen,
  output logic                     o_mem_clken,
  output logic [$clog2(DEPTH)-1:0] o_mem_waddr,
  output logic [WIDTH-1:0]         o_mem_wdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LB = $clog2(BEATS);
  localparam int unsigned TW = 30 - LB;
  localparam logic [LB-1:0] LAST_BEAT = LB'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [LB-1:0]    beat_q, beat_d;
  logic [TW-1:0]    tag_q, tag_d;
  logic             wen_q, wen_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  // Word address of the current beat; its low AW bits are {line index, beat},
  // which is exactly line_tag mod (DEPTH/BEATS) concatenated with the beat.
  logic [29:0]      word_adr;
  logic             addr_unused;

  assign word_adr    = {tag_q, beat_q};
  assign addr_unused = ^i_req_addr[1:0];

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      tag_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tag_q   <= tag_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: request capture, beat sequencing, abort handling.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tag_d   = tag_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    abort_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req && !i_inv) begin
          tag_d   = i_req_addr[31:LB+2];
          beat_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (i_inv) begin
          // Invalidate discards any data acked this cycle; an outstanding
          // beat must still be terminated on the bus before going idle.
          if (i_wb_ack || i_wb_err) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (i_wb_err) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (i_wb_ack) begin
          wen_d   = 1'b1;
          waddr_d = AW'(word_adr);
          wdata_d = i_wb_dat;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_FINISH;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (i_wb_ack || i_wb_err) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode. The invalidate gates the write presented in the same
  // cycle, and in FINISH it turns the completion into an abort.
  always_comb begin
    o_busy      = (state_q != ST_IDLE);
    o_wb_cyc    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    o_wb_stb    = o_wb_cyc;
    o_wb_adr    = {tag_q, beat_q, 2'b00};
    o_mem_wen   = wen_q && !i_inv;
    o_mem_clken = o_mem_wen;
    o_mem_waddr = waddr_q;
    o_mem_wdata = wdata_q;
    o_done      = (state_q == ST_FINISH) && !i_inv;
    o_abort     = abort_q || ((state_q == ST_FINISH) && i_inv);
    o_err       = err_q;
  end

endmodule

// File: tb/tb_zap_mem_fill_ctrl.sv
// Self-checking bench for zap_mem_fill_ctrl with a RAM-write scoreboard.
module tb_zap_mem_fill_ctrl;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned BEATS = 4;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] req_addr;
  logic        busy, done, abort_p, err_p;
  logic        wb_cyc, wb_stb;
  logic [31:0] wb_adr;
  logic        wb_ack, wb_err;
  logic [31:0] wb_dat;
  logic        inv;
  logic        mem_wen, mem_clken;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;

  zap_mem_fill_ctrl #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .BEATS(BEATS)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req      (req),
    .i_req_addr (req_addr),
    .o_busy     (busy),
    .o_done     (done),
    .o_abort    (abort_p),
    .o_err      (err_p),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .o_wb_adr   (wb_adr),
    .i_wb_ack   (wb_ack),
    .i_wb_err   (wb_err),
    .i_wb_dat   (wb_dat),
    .i_inv      (inv),
    .o_mem_wen  (mem_wen),
    .o_mem_clken(mem_clken),
    .o_mem_waddr(mem_waddr),
    .o_mem_wdata(mem_wdata)
  );

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] data;
    int unsigned at;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         ent;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done, n_abort, n_err;
  int unsigned cyc_cnt = 0;
  int unsigned t0;
  logic        req_noise = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_adr(input logic [31:0] a, input int b);
    return (a / 16) * 16 + 32'(b) * 4;
  endfunction

  function automatic logic [31:0] exp_waddr(input logic [31:0] a, input int b);
    return ((a / 16) % (DEPTH / BEATS)) * BEATS + 32'(b);
  endfunction

  // Scoreboard side: every observed RAM write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      check("clken_eq_wen", mem_clken, mem_wen);
      check("stb_eq_cyc", wb_stb, wb_cyc);
      if (mem_wen) begin
        if (exp_q.size() == 0) begin
          check("write_unexpected", mem_wen, 1'b0);
        end else begin
          ent = exp_q.pop_front();
          check("write_waddr", mem_waddr, ent.waddr);
          check("write_wdata", mem_wdata, ent.data);
          check("write_cycle", cyc_cnt, ent.at);
        end
      end
      n_done  += done;
      n_abort += abort_p;
      n_err   += err_p;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_done  = 0;
    n_abort = 0;
    n_err   = 0;
  endtask

  task automatic check_counts(input int d, input int a, input int e);
    check("n_done", n_done, d);
    check("n_abort", n_abort, a);
    check("n_err", n_err, e);
  endtask

  task automatic request(input logic [31:0] addr);
    req      = 1'b1;
    req_addr = addr;
    tick();
    req      = 1'b0;
  endtask

  // Acts as the bus slave for one beat: optional wait states, then ack
  // (plus err/inv if asked). Pushes the expected RAM write when one is due.
  task automatic serve_beat(input logic [31:0] a, input int b, input int waits,
                            input logic [31:0] data, input bit a_err,
                            input bit a_inv, input bit push);
    for (int w = 0; w < waits; w++) begin
      check("cyc_wait", wb_cyc, 1'b1);
      check("adr_hold", wb_adr, exp_adr(a, b));
      req      = req_noise;
      req_addr = 32'h8000_0000;
      tick();
    end
    req = 1'b0;
    check("cyc", wb_cyc, 1'b1);
    check("adr", wb_adr, exp_adr(a, b));
    wb_ack = 1'b1;
    wb_err = a_err;
    inv    = a_inv;
    wb_dat = data;
    if (push && !a_err && !a_inv)
      exp_q.push_back('{waddr: exp_waddr(a, b), data: data, at: cyc_cnt + 1});
    tick();
    wb_ack = 1'b0;
    wb_err = 1'b0;
    inv    = 1'b0;
  endtask

  task automatic full_fill(input logic [31:0] a, input int waits, input logic [31:0] base);
    clear_counts();
    request(a);
    for (int b = 0; b < 4; b++) serve_beat(a, b, waits, base + 32'(b), 1'b0, 1'b0, 1'b1);
    check("finish_done", done, 1'b1);
    check("finish_cyc", wb_cyc, 1'b0);
    check("finish_busy", busy, 1'b1);
    tick();
    check("idle_busy", busy, 1'b0);
    check_counts(1, 0, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 1'b0;
    req_addr = '0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat   = '0;
    inv      = 1'b0;
    clear_counts();
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_cyc", wb_cyc, 1'b0);
    check("rst_adr", wb_adr, 32'h0);
    check("rst_wen", mem_wen, 1'b0);
    check("rst_waddr", mem_waddr, 5'd0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_done", done, 1'b0);
    check("rst_abort", abort_p, 1'b0);
    check("rst_err", err_p, 1'b0);
    rst_n = 1'b1;
    tick();

    // Zero-wait fill with exact cycle positions.
    clear_counts();
    t0 = cyc_cnt;
    request(32'h0000_1234);
    for (int b = 0; b < 4; b++) begin
      check("s1_bus_cycle", cyc_cnt, t0 + 1 + 32'(b));
      serve_beat(32'h0000_1234, b, 0, 32'hA0 + 32'(b), 1'b0, 1'b0, 1'b1);
    end
    check("s1_done", done, 1'b1);
    check("s1_done_cycle", cyc_cnt, t0 + 5);
    tick();
    check("s1_busy_off", busy, 1'b0);
    check_counts(1, 0, 0);

    // Two wait states per beat, with ignored requests while busy.
    req_noise = 1'b1;
    full_fill(32'h0000_1234, 2, 32'hB0);
    req_noise = 1'b0;

    // Request together with invalidate is dropped; invalidate alone in IDLE is harmless.
    req = 1'b1; inv = 1'b1; req_addr = 32'h0000_0100;
    tick();
    req = 1'b0;
    check("drop_busy", busy, 1'b0);
    check("drop_cyc", wb_cyc, 1'b0);
    tick();
    inv = 1'b0;
    check("idle_inv_busy", busy, 1'b0);

    // Invalidate with the ack of beat 1; beat 0 write lands before it.
    clear_counts();
    request(32'h0000_0040);
    serve_beat(32'h0000_0040, 0, 1, 32'hC0, 1'b0, 1'b0, 1'b1);
    serve_beat(32'h0000_0040, 1, 1, 32'hC1, 1'b0, 1'b1, 1'b1);
    check("s3_abort", abort_p, 1'b1);
    check("s3_busy", busy, 1'b0);
    check("s3_cyc", wb_cyc, 1'b0);
    tick();
    check_counts(0, 1, 0);
    check("s3_sb_empty", exp_q.size(), 0);

    // Invalidate while beat 2 is pending: drain, no writes, abort.
    clear_counts();
    request(32'h0000_0F00);
    serve_beat(32'h0000_0F00, 0, 0, 32'hD0, 1'b0, 1'b0, 1'b1);
    serve_beat(32'h0000_0F00, 1, 0, 32'hD1, 1'b0, 1'b0, 1'b0);
    check("s4_adr2", wb_adr, exp_adr(32'h0000_0F00, 2));
    inv = 1'b1;
    tick();
    inv = 1'b0;
    for (int w = 0; w < 2; w++) begin
      check("s4_drain_cyc", wb_cyc, 1'b1);
      check("s4_drain_busy", busy, 1'b1);
      tick();
    end
    check("s4_drain_cyc3", wb_cyc, 1'b1);
    wb_ack = 1'b1; wb_dat = 32'hD2;
    tick();
    wb_ack = 1'b0;
    check("s4_abort", abort_p, 1'b1);
    check("s4_busy", busy, 1'b0);
    tick();
    check_counts(0, 1, 0);

    // Error with ack on beat 0, then an immediate new request.
    clear_counts();
    request(32'h0000_2000);
    serve_beat(32'h0000_2000, 0, 0, 32'hE0, 1'b1, 1'b0, 1'b1);
    check("s5_err", err_p, 1'b1);
    check("s5_cyc", wb_cyc, 1'b0);
    check("s5_busy", busy, 1'b0);
    check_counts(0, 0, 0);
    request(32'h0000_3004);
    for (int b = 0; b < 4; b++) serve_beat(32'h0000_3004, b, 0, 32'hF0 + 32'(b), 1'b0, 1'b0, 1'b1);
    check("s5_done", done, 1'b1);
    tick();
    check_counts(1, 0, 1);

    // Invalidate during FINISH: last write suppressed, abort instead of done.
    clear_counts();
    request(32'h0000_5678);
    for (int b = 0; b < 4; b++) serve_beat(32'h0000_5678, b, 0, 32'h50 + 32'(b), 1'b0, 1'b0, b != 3);
    inv = 1'b1;
    #1;
    check("s6_done", done, 1'b0);
    check("s6_abort", abort_p, 1'b1);
    check("s6_wen", mem_wen, 1'b0);
    tick();
    inv = 1'b0;
    check("s6_busy", busy, 1'b0);
    tick();
    check_counts(0, 1, 0);

    // Asynchronous reset mid-FETCH, then a fresh fill from beat 0.
    request(32'h0000_1234);
    serve_beat(32'h0000_1234, 0, 0, 32'h11, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cyc", wb_cyc, 1'b0);
    check("rst_mid_wen", mem_wen, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    full_fill(32'h0000_1234, 1, 32'h70);

    tick();
    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
